// File: rtl/inst_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - default address width, reset PC and sequential PC step
//   - fetch FSM state encoding (plain 3-bit constants, legacy-compatible)
//   - instruction-word alignment constant used to clean redirect targets
// No ports (package).
// ---------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;

  // Instruction words are 4-byte aligned: this many low PC bits are always 0.
  localparam int unsigned ALIGN_LSB    = 2;

  localparam int unsigned INST_W       = 32;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 3'd0;
  localparam fetch_state_t ST_REQ   = 3'd1;
  localparam fetch_state_t ST_WAIT  = 3'd2;
  localparam fetch_state_t ST_HOLD  = 3'd3;
  localparam fetch_state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl_if
// Bundles the two handshakes owned by the fetch sequencer:
//   imem_req_valid/ready/addr  : request channel to instruction memory
//   imem_rsp_valid/data        : single-outstanding read response
//   inst_valid/ready/data/pc   : fetched instruction towards decode
// modport master : the fetch sequencer side
// modport slave  : the environment (memory + decode) side
// ---------------------------------------------------------------------------
interface inst_fetch_ctrl_if
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ADDR_W-1:0]   imem_req_addr;
  logic                imem_rsp_valid;
  logic [INST_W-1:0]   imem_rsp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_W-1:0]   inst_data;
  logic [ADDR_W-1:0]   inst_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_ctrl_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
// Program-counter register for the fetch sequencer.
//   clock      : single clock, posedge
//   reset      : synchronous active-high, loads RESET_PC
//   load_i     : load load_pc_i (redirect); has priority over inc_i
//   load_pc_i  : new PC value
//   inc_i      : advance by PC_STEP (wraps modulo 2^ADDR_W)
//   pc_o       : current PC
// ---------------------------------------------------------------------------
module fetch_pc_reg
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, issues one read at a time to
// instruction memory and presents each fetched word to decode until it is
// accepted. A one-cycle redirect pulse from the branch unit re-steers the PC
// and discards whatever is in flight or waiting for decode.
//
// Ports
//   clock           in  single clock, all state on posedge
//   reset           in  synchronous, active-high
//   redirect_valid  in  branch/jump taken this cycle
//   redirect_pc     in  redirect target (low two bits ignored)
//   bus             master modport of inst_fetch_ctrl_if:
//                   imem_req_*  request to memory (addr = PC)
//                   imem_rsp_*  read response (one per accepted request)
//                   inst_*      instruction word + its PC towards decode
//
// Zero-wait memory timing: request accepted in cycle N, response in N+1,
// inst_valid in N+2; back-to-back one instruction every three cycles.
// ---------------------------------------------------------------------------
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  inst_fetch_ctrl_if.master   bus
);

  // Clears the sub-word bits of a redirect target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~(ADDR_W'((1 << ALIGN_LSB) - 1));

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic [INST_W-1:0]   inst_data_q;
  logic [INST_W-1:0]   inst_data_d;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic [ADDR_W-1:0]   inst_pc_d;

  logic                pc_load;
  logic                pc_inc;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ALIGN_MASK;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clock     (clock),
    .reset     (reset),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc_aligned),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_comb begin
    state_d     = state_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          // If the old request is accepted in the same cycle its response
          // is still coming and must be thrown away.
          state_d = bus.imem_req_ready ? ST_DRAIN : ST_REQ;
        end else if (bus.imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          // A response arriving together with the redirect is the one being
          // dropped; nothing is left outstanding, so refetch straight away
          // instead of draining a response that will never come.
          state_d = bus.imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (bus.imem_rsp_valid) begin
          inst_data_d = bus.imem_rsp_data;
          inst_pc_d   = pc;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          // Redirect wins over a same-cycle accept: the held word is stale.
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (bus.inst_ready) begin
          pc_inc  = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
        end
        if (bus.imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  assign bus.imem_req_valid = (state_q == ST_REQ);
  // PC register holds RESET_PC in IDLE; keep the address bus quiet there.
  assign bus.imem_req_addr  = (state_q == ST_IDLE) ? '0 : pc;
  assign bus.inst_valid     = (state_q == ST_HOLD);
  assign bus.inst_data      = inst_data_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam int unsigned AW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  inst_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W   (AW),
    .RESET_PC (RPC),
    .PC_STEP  (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h",
               name, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table: inputs applied for one cycle, outputs expected
  // right after the following clock edge.
  // -------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rdy, input logic rspv,
                     input logic [31:0] rspd, input logic irdy,
                     input logic redir, input logic [31:0] rpc,
                     input logic e_rv, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_data,
                     input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.irdy = irdy;
    v.redir = redir; v.rpc = rpc; v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_data = e_data; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rspv,
                       input logic [31:0] rspd, input logic irdy,
                       input logic redir, input logic [31:0] rpc);
    reset              = rst;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rspv;
    bus.imem_rsp_data  = rspd;
    bus.inst_ready     = irdy;
    redirect_valid     = redir;
    redirect_pc        = rpc;
  endtask

  // -------------------------------------------------------------------------
  // Reference model (transaction level): tracks the architectural PC, whether
  // a read is outstanding, whether that read has been cancelled, and whether
  // a fetched word is waiting for decode.
  // -------------------------------------------------------------------------
  bit          m_idle;
  bit          m_out;
  bit          m_drop;
  bit          m_live;
  logic [31:0] m_pc;
  logic [31:0] m_live_pc;

  task automatic model_step(input bit rst, input bit rdy, input bit rspv,
                            input bit irdy, input bit redir,
                            input logic [31:0] rpc);
    bit req;
    bit was_live;
    if (rst) begin
      m_idle = 1; m_out = 0; m_drop = 0; m_live = 0; m_pc = RPC;
    end else if (m_idle) begin
      m_idle = 0;
    end else begin
      req      = !m_out && !m_live;
      was_live = m_live;
      if (req && rdy) begin
        m_out  = 1;
        m_drop = redir;
      end else if (m_out && rspv) begin
        m_out = 0;
        if (!m_drop && !redir) begin
          m_live    = 1;
          m_live_pc = m_pc;
        end
        m_drop = 0;
      end else if (m_out && redir) begin
        m_drop = 1;
      end
      if (was_live && (redir || irdy)) begin
        m_live = 0;
        if (!redir) m_pc = m_pc + 32'd4;
      end
      if (redir) m_pc = rpc & ~32'h3;
    end
  endtask

  task automatic model_compare(input int cyc);
    if (m_idle) begin
      check("rnd_idle_req_valid", cyc, 32'(bus.imem_req_valid), 32'd0);
      check("rnd_idle_addr",      cyc, bus.imem_req_addr,       32'd0);
      check("rnd_idle_inst_valid", cyc, 32'(bus.inst_valid),    32'd0);
      check("rnd_idle_inst_data", cyc, bus.inst_data,           32'd0);
    end else begin
      check("rnd_req_valid", cyc, 32'(bus.imem_req_valid),
            32'(!m_out && !m_live));
      if (!m_out && !m_live)
        check("rnd_req_addr", cyc, bus.imem_req_addr, m_pc);
      check("rnd_inst_valid", cyc, 32'(bus.inst_valid), 32'(m_live));
      if (m_live) begin
        check("rnd_inst_pc",   cyc, bus.inst_pc,   m_live_pc);
        check("rnd_inst_data", cyc, bus.inst_data, m_live_pc + 32'h1000);
      end
    end
  endtask

  // Memory environment for the random phase
  bit          mem_pend;
  int          mem_dly;
  logic [31:0] mem_addr;

  initial begin
    int          hs_cyc;
    int          iv1;
    int          iv2;
    bit          pend;
    bit          nxt;
    logic [31:0] paddr;
    logic [31:0] naddr;
    bit          r_rst, r_rdy, r_rspv, r_irdy, r_redir;
    logic [31:0] r_rspd, r_rpc;

    drive(1, 0, 0, 0, 0, 0, 0);

    // ---------------- directed table ----------------
    //   rst rdy rspv rspd        irdy redir rpc        | rv addr      iv data        pc
    add(1, 0, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h0,   0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1000,  1, 0, 32'h0,     0, 32'h0,   1, 32'h1000, 32'h0);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h4,   0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1004,  1, 0, 32'h0,     0, 32'h0,   1, 32'h1004, 32'h4);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h8,   0, 32'h0,    32'h0);
    // request stalled by memory for three cycles
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h8,   0, 32'h0,    32'h0);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h8,   0, 32'h0,    32'h0);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h8,   0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    // decode stalls in HOLD
    add(0, 0, 1, 32'h1008,  0, 0, 32'h0,     0, 32'h0,   1, 32'h1008, 32'h8);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   1, 32'h1008, 32'h8);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   1, 32'h1008, 32'h8);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   1, 32'h1008, 32'h8);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   1, 32'h1008, 32'h8);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'hC,   0, 32'h0,    32'h0);
    // redirect while waiting: stale response drained
    add(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 0, 32'h0,     1, 1, 32'h100,   0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h100C,  1, 0, 32'h0,     1, 32'h100, 0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1100,  0, 0, 32'h0,     0, 32'h0,   1, 32'h1100, 32'h100);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h104, 0, 32'h0,    32'h0);
    // unaligned redirect in REQ without ready: no drain
    add(0, 0, 0, 32'h0,     1, 1, 32'h203,   1, 32'h200, 0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1200,  0, 0, 32'h0,     0, 32'h0,   1, 32'h1200, 32'h200);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h204, 0, 32'h0,    32'h0);
    // reset while waiting, then restart from RESET_PC
    add(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(1, 0, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h0,   0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1000,  0, 0, 32'h0,     0, 32'h0,   1, 32'h1000, 32'h0);
    // redirect in HOLD with inst_ready: word discarded, no increment
    add(0, 0, 0, 32'h0,     1, 1, 32'h40,    1, 32'h40,  0, 32'h0,    32'h0);
    // redirect in REQ with ready -> drain; second redirect while draining
    add(0, 1, 0, 32'h0,     1, 1, 32'h80,    0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 0, 32'h0,     1, 1, 32'h90,    0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1234,  1, 0, 32'h0,     1, 32'h90,  0, 32'h0,    32'h0);
    // response outside WAIT/DRAIN ignored
    add(0, 0, 1, 32'hDEAD,  1, 0, 32'h0,     1, 32'h90,  0, 32'h0,    32'h0);
    add(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,   0, 32'h0,    32'h0);
    add(0, 0, 1, 32'h1090,  0, 0, 32'h0,     0, 32'h0,   1, 32'h1090, 32'h90);
    add(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h94,  0, 32'h0,    32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd,
            vecs[i].irdy, vecs[i].redir, vecs[i].rpc);
      @(posedge clock);
      #1;
      check("tbl_req_valid",  i, 32'(bus.imem_req_valid), 32'(vecs[i].e_rv));
      check("tbl_inst_valid", i, 32'(bus.inst_valid),     32'(vecs[i].e_iv));
      if (vecs[i].e_rv || vecs[i].rst)
        check("tbl_req_addr", i, bus.imem_req_addr, vecs[i].e_addr);
      if (vecs[i].e_iv || vecs[i].rst) begin
        check("tbl_inst_data", i, bus.inst_data, vecs[i].e_data);
        check("tbl_inst_pc",   i, bus.inst_pc,   vecs[i].e_pc);
      end
    end

    // ---------------- latency / throughput, zero-wait memory ----------------
    @(negedge clock);
    drive(1, 1, 0, 0, 1, 0, 0);
    @(posedge clock);
    #1;
    hs_cyc = -1; iv1 = -1; iv2 = -1; pend = 0; paddr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      nxt   = bus.imem_req_valid;
      naddr = bus.imem_req_addr;
      if (nxt && hs_cyc < 0) hs_cyc = c;
      drive(0, 1, pend, paddr + 32'h1000, 1, 0, 0);
      pend  = nxt;
      paddr = naddr;
      @(posedge clock);
      #1;
      if (bus.inst_valid) begin
        if (iv1 < 0) iv1 = c + 1;
        else if (iv2 < 0) iv2 = c + 1;
      end
    end
    check("latency_req_to_inst", 0, 32'(iv1 - hs_cyc), 32'd2);
    check("throughput_cycles",   0, 32'(iv2 - iv1),    32'd3);

    // ---------------- randomized phase against the model ----------------
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    mem_pend = 0; mem_dly = 0; mem_addr = 0;
    @(posedge clock);
    #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_compare(cyc);
      @(negedge clock);
      r_rst   = ($urandom_range(0, 199) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_irdy  = ($urandom_range(0, 2) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_rpc   = $urandom;
      if (mem_pend && mem_dly == 0) begin
        r_rspv = 1; r_rspd = mem_addr + 32'h1000;
      end else if (!mem_pend && $urandom_range(0, 7) == 0) begin
        r_rspv = 1; r_rspd = $urandom;
      end else begin
        r_rspv = 0; r_rspd = $urandom;
      end
      drive(r_rst, r_rdy, r_rspv, r_rspd, r_irdy, r_redir, r_rpc);
      if (r_rst) begin
        mem_pend = 0;
      end else begin
        if (mem_pend && r_rspv) mem_pend = 0;
        else if (mem_pend) mem_dly = mem_dly - 1;
        if (bus.imem_req_valid && r_rdy) begin
          mem_pend = 1;
          mem_addr = bus.imem_req_addr;
          mem_dly  = $urandom_range(0, 2);
        end
      end
      model_step(r_rst, r_rdy, r_rspv, r_irdy, r_redir, r_rpc);
      @(posedge clock);
      #1;
    end
    model_compare(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
